// File: rtl/rot_pkg.sv
// Shared types and step codes for the rotary encoder front-end.
// Optional push switch support is enabled by the ROT_PRESS_EN macro.
package rot_pkg;

    localparam logic [1:0] RLROT_IDLE  = 2'b00;
    localparam logic [1:0] RLROT_RIGHT = 2'b11;
    localparam logic [1:0] RLROT_LEFT  = 2'b10;

    typedef enum logic [2:0] {
        REST,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3,
        ERR
    } rot_state_t;

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one encoder input line.
// A new level is taken only after DEBOUNCE_CYCLES consecutive differing samples.
module rot_debounce #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          DEB_W           = 16,
    parameter logic        RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // Bring the asynchronous line into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Count run length of samples that disagree with the held level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Held level and run-length counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/rotary_step_decoder.sv
// Quadrature detent decoder: one registered rlrot pulse per full detent.
// Define ROT_PRESS_EN to add the debounced push switch and push_pulse.
module rotary_step_decoder
    import rot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DEB_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rot_a,
    input  logic       rot_b,
    output logic [1:0] rlrot,
    output logic       seq_err
`ifdef ROT_PRESS_EN
    ,
    input  logic       rot_push,
    output logic       push_pulse
`endif
);

    logic       a_db;
    logic       b_db;
    logic [1:0] ab;

    rot_state_t state_q;
    rot_state_t state_d;
    logic [1:0] rlrot_q;
    logic [1:0] rlrot_d;
    logic       seq_err_q;
    logic       seq_err_d;

    rot_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_W           (DEB_W),
        .RESET_VAL       (1'b1)
    ) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_a),
        .dout (a_db)
    );

    rot_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_W           (DEB_W),
        .RESET_VAL       (1'b1)
    ) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_b),
        .dout (b_db)
    );

    assign ab = {a_db, b_db};

    // Next-state and step/error decode from the debounced pair.
    always_comb begin
        state_d   = state_q;
        rlrot_d   = RLROT_IDLE;
        seq_err_d = 1'b0;
        unique case (state_q)
            REST: begin
                if (ab == 2'b01) state_d = CW1;
                if (ab == 2'b10) state_d = CCW1;
                if (ab == 2'b00) state_d = ERR;
            end
            CW1: begin
                if (ab == 2'b00) state_d = CW2;
                if (ab == 2'b11) state_d = REST;
                if (ab == 2'b10) state_d = ERR;
            end
            CW2: begin
                if (ab == 2'b10) state_d = CW3;
                if (ab == 2'b01) state_d = CW1;
                if (ab == 2'b11) state_d = ERR;
            end
            CW3: begin
                if (ab == 2'b11) begin
                    state_d = REST;
                    rlrot_d = RLROT_RIGHT;
                end
                if (ab == 2'b00) state_d = CW2;
                if (ab == 2'b01) state_d = ERR;
            end
            CCW1: begin
                if (ab == 2'b00) state_d = CCW2;
                if (ab == 2'b11) state_d = REST;
                if (ab == 2'b01) state_d = ERR;
            end
            CCW2: begin
                if (ab == 2'b01) state_d = CCW3;
                if (ab == 2'b10) state_d = CCW1;
                if (ab == 2'b11) state_d = ERR;
            end
            CCW3: begin
                if (ab == 2'b11) begin
                    state_d = REST;
                    rlrot_d = RLROT_LEFT;
                end
                if (ab == 2'b00) state_d = CCW2;
                if (ab == 2'b10) state_d = ERR;
            end
            ERR: begin
                if (ab == 2'b11) state_d = REST;
            end
            default: state_d = REST;
        endcase
        if (state_d == ERR && state_q != ERR) seq_err_d = 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REST;
            rlrot_q   <= RLROT_IDLE;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rlrot_q   <= rlrot_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign rlrot   = rlrot_q;
    assign seq_err = seq_err_q;

`ifdef ROT_PRESS_EN
    logic push_db;
    logic push_prev_q;
    logic push_pulse_q;

    rot_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_W           (DEB_W),
        .RESET_VAL       (1'b0)
    ) u_deb_push (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_push),
        .dout (push_db)
    );

    // Rising-edge detect on the debounced push level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_prev_q  <= 1'b0;
            push_pulse_q <= 1'b0;
        end else begin
            push_prev_q  <= push_db;
            push_pulse_q <= push_db & ~push_prev_q;
        end
    end

    assign push_pulse = push_pulse_q;
`endif

endmodule

// File: tb/tb_rotary_step_decoder.sv
// Directed bench for rotary_step_decoder with DEBOUNCE_CYCLES=4.
// Define ROT_PRESS_EN to also exercise the push switch path.
module tb_rotary_step_decoder;

    logic       clk;
    logic       rst;
    logic       rot_a;
    logic       rot_b;
    logic [1:0] rlrot;
    logic       seq_err;
`ifdef ROT_PRESS_EN
    logic       rot_push;
    logic       push_pulse;
`endif

    int total;
    int bad;
    int cyc;
    int n_right;
    int n_left;
    int n_err;
    int n_push;
    int n_code01;
    int n_overlap;
    int last_right;
    int t_drive;

    rotary_step_decoder #(
        .DEBOUNCE_CYCLES (4),
        .DEB_W           (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rot_a      (rot_a),
        .rot_b      (rot_b),
        .rlrot      (rlrot),
        .seq_err    (seq_err)
`ifdef ROT_PRESS_EN
        ,
        .rot_push   (rot_push),
        .push_pulse (push_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (rlrot == 2'b11) begin
            n_right    = n_right + 1;
            last_right = cyc;
        end
        if (rlrot == 2'b10) n_left = n_left + 1;
        if (rlrot == 2'b01) n_code01 = n_code01 + 1;
        if (seq_err) n_err = n_err + 1;
        if (seq_err && rlrot != 2'b00) n_overlap = n_overlap + 1;
`ifdef ROT_PRESS_EN
        if (push_pulse) n_push = n_push + 1;
`endif
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        if (obs != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_right = 0;
        n_left  = 0;
        n_err   = 0;
        n_push  = 0;
        last_right = -1;
    endtask

    task automatic set_ab(input logic [1:0] ab, input int n);
        @(negedge clk);
        rot_a   = ab[1];
        rot_b   = ab[0];
        t_drive = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic cw();
        set_ab(2'b01, 10);
        set_ab(2'b00, 10);
        set_ab(2'b10, 10);
        set_ab(2'b11, 10);
    endtask

    task automatic ccw();
        set_ab(2'b10, 10);
        set_ab(2'b00, 10);
        set_ab(2'b01, 10);
        set_ab(2'b11, 10);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        n_code01 = 0;
        n_overlap = 0;
        t_drive = 0;
        clr();
        rst = 1'b1;
        rot_a = 1'b1;
        rot_b = 1'b1;
`ifdef ROT_PRESS_EN
        rot_push = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_rlrot", int'(rlrot), 0);
        chk("reset_seq_err", int'(seq_err), 0);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        chk("idle_right", n_right, 0);
        chk("idle_err", n_err, 0);

        clr();
        cw();
        chk("cw_pulses", n_right, 1);
        chk("cw_latency", last_right - t_drive, 7);
        chk("cw_left", n_left, 0);

        clr();
        ccw();
        chk("ccw_pulses", n_left, 1);
        chk("ccw_right", n_right, 0);

        clr();
        repeat (3) ccw();
        chk("b2b_pulses", n_left, 3);

        clr();
        for (int i = 0; i < 5; i++) begin
            set_ab(2'b01, 3);
            set_ab(2'b11, 3);
        end
        chk("bounce_quiet", n_right + n_left + n_err, 0);
        cw();
        chk("bounce_cw", n_right, 1);
        chk("bounce_err", n_err, 0);

        clr();
        set_ab(2'b00, 10);
        chk("illegal_err", n_err, 1);
        chk("illegal_rl", n_right + n_left, 0);
        set_ab(2'b11, 10);
        chk("err_hold", n_err, 1);
        cw();
        chk("post_err_cw", n_right, 1);

        clr();
        set_ab(2'b01, 10);
        set_ab(2'b00, 10);
        set_ab(2'b01, 10);
        set_ab(2'b11, 10);
        chk("reverse_none", n_right + n_left + n_err, 0);

        clr();
        set_ab(2'b01, 10);
        set_ab(2'b00, 10);
        set_ab(2'b10, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rlrot", int'(rlrot), 0);
        chk("rst_seq_err", int'(seq_err), 0);
        rot_a = 1'b1;
        rot_b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_pulse", n_right + n_left + n_err, 0);
        cw();
        chk("post_rst_cw", n_right, 1);

`ifdef ROT_PRESS_EN
        clr();
        @(negedge clk);
        rot_push = 1'b1;
        repeat (20) @(negedge clk);
        rot_push = 1'b0;
        repeat (20) @(negedge clk);
        chk("push_pulse", n_push, 1);
`endif

        chk("code01_never", n_code01, 0);
        chk("no_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
